// File: rtl/phaser_scheduler_pkg.sv
// Shared definitions for the phaser scheduler: state encodings, the phaser
// unfire code and the default per-wait timeout.
package phaser_scheduler_pkg;

    typedef enum logic [3:0] {
        SS_IDLE        = 4'd0,
        SS_SELECT      = 4'd1,
        SS_FIRE        = 4'd2,
        SS_WAIT_BUSY   = 4'd3,
        SS_WAIT_UNFIRE = 4'd4,
        SS_UNFIRE      = 4'd5,
        SS_WAIT_IDLE   = 4'd6,
        SS_ABORT       = 4'd7,
        SS_DONE        = 4'd8
    } sched_state_t;

    localparam logic [2:0]  PH_UNFIRE       = 3'd6;
    localparam logic [15:0] DEFAULT_TIMEOUT = 16'd50000;

    // States in which the timeout counter runs.
    function automatic logic is_wait_state(input sched_state_t s);
        return (s == SS_WAIT_BUSY) || (s == SS_WAIT_UNFIRE) || (s == SS_WAIT_IDLE);
    endfunction

    // States in which the serviced phaser sees its fire line high.
    function automatic logic is_fire_state(input sched_state_t s);
        return (s == SS_FIRE) || (s == SS_WAIT_BUSY) || (s == SS_WAIT_UNFIRE);
    endfunction

endpackage

// File: rtl/phaser_scheduler_lowest_set_sel.sv
// Priority encoder: index of the lowest set bit of vec, with a flag when no
// bit is set (idx is then 0).
module lowest_set_sel #(
    parameter int W  = 7,
    parameter int IW = 3
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          none
);

    // Scanning downward lets the lowest set bit be the last one written.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx  = IW'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/phaser_scheduler.sv
// Walks a mask of DCM phasers lowest index first, running the fire/unfire
// handshake on one phaser at a time with per-wait timeout recovery.
module phaser_scheduler
    import phaser_scheduler_pkg::*;
#(
    parameter int          NCH     = 7,
    parameter logic [15:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clock,
    input  logic             global_reset_n,
    input  logic             start,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [NCH-1:0]   ph_busy,
    input  logic [3*NCH-1:0] ph_sm_vec,
    output logic [NCH-1:0]   ph_fire,
    output logic [NCH-1:0]   ph_reset,
    output logic             sched_busy,
    output logic [2:0]       cur_ch,
    output logic             done,
    output logic [NCH-1:0]   err,
    output logic [3:0]       sm_vec
);

    sched_state_t   state;
    sched_state_t   nxt;
    logic [NCH-1:0] pending;
    logic [15:0]    cnt;
    logic           start_q;

    logic [2:0]     sel_idx;
    logic           sel_none;
    logic [2:0]     nxt_cur;
    logic           cur_busy;
    logic [2:0]     cur_sm;
    logic [NCH-1:0] cur_bit;
    logic           accept;
    logic           release_ch;
    logic           timeout_hit;

    function automatic logic [NCH-1:0] onehot(input logic [2:0] idx);
        logic [NCH-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == 3'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    lowest_set_sel #(
        .W  (NCH),
        .IW (3)
    ) u_sel (
        .vec  (pending),
        .idx  (sel_idx),
        .none (sel_none)
    );

    // Route the serviced channel's phaser status without a variable part-select.
    always_comb begin
        cur_busy = 1'b0;
        cur_sm   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cur_ch == 3'(i)) begin
                cur_busy = ph_busy[i];
                cur_sm   = ph_sm_vec[3*i +: 3];
            end
        end
    end

    assign cur_bit     = onehot(cur_ch);
    assign accept      = (state == SS_IDLE) && start && !start_q;
    assign timeout_hit = (cnt == TIMEOUT);

    always_comb begin
        nxt = state;
        unique case (state)
            SS_IDLE:        if (accept) nxt = SS_SELECT;
            SS_SELECT:      nxt = sel_none ? SS_DONE : SS_FIRE;
            SS_FIRE:        nxt = SS_WAIT_BUSY;
            SS_WAIT_BUSY: begin
                if (timeout_hit)   nxt = SS_ABORT;
                else if (cur_busy) nxt = SS_WAIT_UNFIRE;
            end
            SS_WAIT_UNFIRE: begin
                if (timeout_hit)              nxt = SS_ABORT;
                else if (cur_sm == PH_UNFIRE) nxt = SS_UNFIRE;
            end
            SS_UNFIRE:      nxt = SS_WAIT_IDLE;
            SS_WAIT_IDLE: begin
                if (timeout_hit)    nxt = SS_ABORT;
                else if (!cur_busy) nxt = SS_SELECT;
            end
            SS_ABORT:       nxt = SS_SELECT;
            SS_DONE:        nxt = SS_IDLE;
            default:        nxt = SS_IDLE;
        endcase
    end

    always_comb begin
        nxt_cur = cur_ch;
        if (nxt == SS_IDLE)
            nxt_cur = '0;
        else if ((state == SS_SELECT) && !sel_none)
            nxt_cur = sel_idx;
    end

    assign release_ch = (state == SS_ABORT) ||
                        ((state == SS_WAIT_IDLE) && (nxt == SS_SELECT));

    // Outputs are decoded from the next state so they move with the state.
    always_ff @(posedge clock) begin
        if (!global_reset_n) begin
            state      <= SS_IDLE;
            pending    <= '0;
            cnt        <= '0;
            start_q    <= 1'b0;
            cur_ch     <= '0;
            ph_fire    <= '0;
            ph_reset   <= '0;
            sched_busy <= 1'b0;
            done       <= 1'b0;
            err        <= '0;
            sm_vec     <= '0;
        end else begin
            state   <= nxt;
            start_q <= start;
            cur_ch  <= nxt_cur;

            if (nxt != state)
                cnt <= '0;
            else if (is_wait_state(state))
                cnt <= cnt + 16'd1;

            if (accept)
                pending <= ch_mask;
            else if (release_ch)
                pending <= pending & ~cur_bit;

            ph_fire    <= is_fire_state(nxt) ? onehot(nxt_cur) : '0;
            ph_reset   <= (nxt == SS_ABORT) ? cur_bit : '0;
            sched_busy <= (nxt != SS_IDLE);
            sm_vec     <= nxt;

            if (accept) begin
                done <= 1'b0;
                err  <= '0;
            end else begin
                if (state == SS_DONE) done <= 1'b1;
                if (nxt == SS_ABORT)  err  <= err | cur_bit;
            end
        end
    end

endmodule

// File: tb/tb_phaser_scheduler.sv
// Bench for phaser_scheduler: behavioural phasers, a sequential reference
// thread compared every cycle, plus directed scenario checks.
module tb_phaser_scheduler;
    import phaser_scheduler_pkg::*;

    localparam int NCH = 7;
    localparam int TMO = 20;

    localparam int M_NORMAL = 0;
    localparam int M_NOBUSY = 1;
    localparam int M_STUCK  = 2;
    localparam int M_HOLD   = 3;

    logic             clock = 1'b0;
    logic             global_reset_n = 1'b0;
    logic             start = 1'b0;
    logic [NCH-1:0]   ch_mask = '0;
    logic [NCH-1:0]   ph_busy = '0;
    logic [3*NCH-1:0] ph_sm_vec = '0;
    logic [NCH-1:0]   ph_fire;
    logic [NCH-1:0]   ph_reset;
    logic             sched_busy;
    logic [2:0]       cur_ch;
    logic             done;
    logic [NCH-1:0]   err;
    logic [3:0]       sm_vec;

    phaser_scheduler #(
        .NCH     (NCH),
        .TIMEOUT (16'(TMO))
    ) dut (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .start          (start),
        .ch_mask        (ch_mask),
        .ph_busy        (ph_busy),
        .ph_sm_vec      (ph_sm_vec),
        .ph_fire        (ph_fire),
        .ph_reset       (ph_reset),
        .sched_busy     (sched_busy),
        .cur_ch         (cur_ch),
        .done           (done),
        .err            (err),
        .sm_vec         (sm_vec)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural phasers ----------------
    int mode [NCH];
    int dly  [NCH];
    int pst  [NCH];
    int pcnt [NCH];

    initial begin
        for (int i = 0; i < NCH; i++) begin
            mode[i] = M_NORMAL; dly[i] = 3; pst[i] = 0; pcnt[i] = 0;
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < NCH; i++) begin
            if (!global_reset_n || ph_reset[i]) begin
                pst[i] = 0; pcnt[i] = 0; ph_busy[i] = 1'b0; ph_sm_vec[3*i +: 3] = 3'd0;
            end else begin
                case (pst[i])
                    0: if (ph_fire[i] && mode[i] != M_NOBUSY) begin pst[i] = 1; pcnt[i] = 0; end
                    1: begin
                        pcnt[i]++;
                        if (pcnt[i] >= dly[i]) begin
                            ph_busy[i] = 1'b1; ph_sm_vec[3*i +: 3] = 3'd2; pst[i] = 2; pcnt[i] = 0;
                        end
                    end
                    2: begin
                        pcnt[i]++;
                        if (mode[i] == M_STUCK) ph_sm_vec[3*i +: 3] = 3'd5;
                        else if (pcnt[i] >= dly[i]) begin ph_sm_vec[3*i +: 3] = 3'd6; pst[i] = 3; end
                    end
                    3: if (!ph_fire[i]) begin pst[i] = 4; pcnt[i] = 0; end
                    4: begin
                        if (mode[i] != M_HOLD) pcnt[i]++;
                        if (pcnt[i] >= dly[i]) begin
                            ph_busy[i] = 1'b0; ph_sm_vec[3*i +: 3] = 3'd0; pst[i] = 0;
                        end
                    end
                    default: pst[i] = 0;
                endcase
            end
        end
    end

    // ---------------- reference thread ----------------
    logic [NCH-1:0]   m_fire, m_reset, m_err, m_mask, m_pbusy;
    logic [3*NCH-1:0] m_psm;
    logic [2:0]       m_cur;
    logic [3:0]       m_sm;
    logic             m_busy, m_done, m_sq, m_edge, m_rst;

    task automatic m_clear();
        m_fire = '0; m_reset = '0; m_err = '0; m_cur = '0;
        m_sm = '0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        m_rst   = !global_reset_n;
        m_edge  = start && !m_sq;
        m_sq    = m_rst ? 1'b0 : start;
        m_mask  = ch_mask;
        m_pbusy = ph_busy;
        m_psm   = ph_sm_vec;
        if (m_rst) m_clear();
    endtask

    // kind 0: busy rise, 1: unfire code, 2: busy fall. res 0 ok, 1 timeout, 2 reset.
    // The wait counter reads 0 on entry, so TMO+1 cycles are spent before abort.
    task automatic wait_for(input int kind, input int ch, output int res);
        int c = 0;
        forever begin
            tick();
            if (m_rst) begin res = 2; return; end
            if (c == TMO) begin res = 1; return; end
            if ((kind == 0 && m_pbusy[ch]) ||
                (kind == 1 && m_psm[3*ch +: 3] == 3'd6) ||
                (kind == 2 && !m_pbusy[ch])) begin res = 0; return; end
            c++;
        end
    endtask

    task automatic run_seq();
        logic [NCH-1:0] pend;
        int ch, res;
        pend = m_mask; m_done = 1'b0; m_err = '0; m_busy = 1'b1; m_sm = SS_SELECT;
        forever begin
            tick(); if (m_rst) return;
            if (pend == '0) begin
                m_sm = SS_DONE;
                tick(); if (m_rst) return;
                m_sm = SS_IDLE; m_busy = 1'b0; m_done = 1'b1; m_cur = '0;
                return;
            end
            ch = 0;
            while (!pend[ch]) ch++;
            m_cur = 3'(ch); m_sm = SS_FIRE; m_fire = '0; m_fire[ch] = 1'b1;
            tick(); if (m_rst) return;
            m_sm = SS_WAIT_BUSY;
            wait_for(0, ch, res);
            if (res == 0) begin m_sm = SS_WAIT_UNFIRE; wait_for(1, ch, res); end
            if (res == 0) begin
                m_sm = SS_UNFIRE; m_fire = '0;
                tick(); if (m_rst) return;
                m_sm = SS_WAIT_IDLE;
                wait_for(2, ch, res);
            end
            if (res == 2) return;
            if (res == 1) begin
                m_sm = SS_ABORT; m_fire = '0; m_reset = '0; m_reset[ch] = 1'b1; m_err[ch] = 1'b1;
                tick(); if (m_rst) return;
                m_reset = '0;
            end
            pend[ch] = 1'b0; m_sm = SS_SELECT;
        end
    endtask

    initial begin
        m_clear(); m_sq = 1'b0; m_edge = 1'b0; m_rst = 1'b1;
        forever begin
            tick();
            if (!m_rst && m_edge) run_seq();
        end
    end

    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            check("ph_fire",    32'(ph_fire),    32'(m_fire));
            check("ph_reset",   32'(ph_reset),   32'(m_reset));
            check("sched_busy", 32'(sched_busy), 32'(m_busy));
            check("cur_ch",     32'(cur_ch),     32'(m_cur));
            check("done",       32'(done),       32'(m_done));
            check("err",        32'(err),        32'(m_err));
            check("sm_vec",     32'(sm_vec),     32'(m_sm));
            check("fire_onehot0",  32'($onehot0(ph_fire)),  32'd1);
            check("reset_onehot0", 32'($onehot0(ph_reset)), 32'd1);
        end
    end

    // ---------------- directed scenarios ----------------
    int fire_first [NCH];
    int fire_last  [NCH];
    int rst_cnt    [NCH];
    int rst_k      [NCH];
    logic [NCH-1:0] fire_seen;
    logic [NCH-1:0] fire_at_rst;
    int done_rises, done_k, busy_fall_k, unfire_wait_cycles;

    // k counts edges after the accepted start edge (k=0 is the state it entered).
    task automatic run_watch(input logic [NCH-1:0] m, input int budget, input bit restart_mid);
        logic done_prev;
        for (int i = 0; i < NCH; i++) begin
            fire_first[i] = -1; fire_last[i] = -1; rst_cnt[i] = 0; rst_k[i] = -1;
        end
        fire_seen = '0; fire_at_rst = '0; done_rises = 0; done_k = -1;
        busy_fall_k = -1; unfire_wait_cycles = 0;
        @(negedge clock);
        ch_mask = m; start = 1'b1;
        done_prev = done;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (k == 0) start = 1'b0;
            if (restart_mid && k == 5) begin start = 1'b1; ch_mask = '1; end
            if (restart_mid && k == 7) start = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (ph_fire[i]) begin
                    if (fire_first[i] < 0) fire_first[i] = k;
                    fire_last[i] = k; fire_seen[i] = 1'b1;
                end
                if (ph_reset[i]) begin rst_cnt[i]++; rst_k[i] = k; fire_at_rst = ph_fire; end
            end
            if (done && !done_prev) begin done_rises++; done_k = k; end
            done_prev = done;
            if (sm_vec == 4'd4) unfire_wait_cycles++;
            if (!sched_busy) begin busy_fall_k = k; break; end
        end
        check("seq_returns_idle", 32'(sched_busy), 32'd0);
    endtask

    task automatic set_modes(input int md, input int d);
        for (int i = 0; i < NCH; i++) begin mode[i] = md; dly[i] = d; end
    endtask

    initial begin
        int n;
        logic [NCH-1:0] rm;
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [NCH-1:0] rm;

        // Reset state
        global_reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        check("rst_sm_vec", 32'(sm_vec), 32'd0);
        check("rst_fire",   32'(ph_fire), 32'd0);
        check("rst_busy",   32'(sched_busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        global_reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Nominal two-channel run, ~40-cycle phasers
        set_modes(M_NORMAL, 12);
        run_watch(7'b0000101, 400, 1'b0);
        check("nom_fire_seen", 32'(fire_seen), 32'h05);
        check("nom_order", 32'(fire_last[0] < fire_first[2]), 32'd1);
        check("nom_fire0_at_k1", 32'(fire_first[0]), 32'd1);
        check("nom_done", 32'(done), 32'd1);
        check("nom_err", 32'(err), 32'd0);
        check("nom_cur_ch", 32'(cur_ch), 32'd0);

        // Empty mask
        run_watch(7'b0000000, 50, 1'b0);
        check("empty_done_k", 32'(done_k), 32'd2);
        check("empty_busy_fall_k", 32'(busy_fall_k), 32'd2);
        check("empty_no_fire", 32'(fire_seen), 32'd0);

        // Timeout in WAIT_BUSY on channel 1, channel 3 still serviced
        set_modes(M_NORMAL, 4);
        mode[1] = M_NOBUSY;
        run_watch(7'b0001010, 400, 1'b0);
        check("tmo_err", 32'(err), 32'h02);
        check("tmo_rst1_once", 32'(rst_cnt[1]), 32'd1);
        check("tmo_rst3_none", 32'(rst_cnt[3]), 32'd0);
        check("tmo_ch3_fired", 32'(fire_seen[3]), 32'd1);
        check("tmo_done", 32'(done), 32'd1);

        // Stuck in WAIT_UNFIRE on channel 0
        set_modes(M_NORMAL, 4);
        mode[0] = M_STUCK;
        run_watch(7'b0000001, 400, 1'b0);
        check("stuck_wait_cycles", 32'(unfire_wait_cycles), 32'(TMO + 1));
        check("stuck_fire_low_at_rst", 32'(fire_at_rst), 32'd0);
        check("stuck_fire_drop_same_cycle", 32'(fire_last[0] + 1), 32'(rst_k[0]));
        check("stuck_err", 32'(err), 32'h01);

        // Start edge while busy is ignored
        set_modes(M_NORMAL, 10);
        run_watch(7'b0000001, 400, 1'b1);
        check("restart_one_done", 32'(done_rises), 32'd1);
        check("restart_pending_kept", 32'(fire_seen), 32'h01);

        // Reset during WAIT_UNFIRE
        @(negedge clock);
        ch_mask = 7'b0000011; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (sm_vec != 4'd4 && n < 200) begin @(negedge clock); n++; end
        check("reach_wait_unfire", 32'(sm_vec), 32'd4);
        global_reset_n = 1'b0;
        @(negedge clock);
        check("midrst_sm_vec", 32'(sm_vec), 32'd0);
        check("midrst_fire", 32'(ph_fire), 32'd0);
        check("midrst_busy", 32'(sched_busy), 32'd0);
        check("midrst_cur", 32'(cur_ch), 32'd0);
        global_reset_n = 1'b1;
        run_watch(7'b0000011, 400, 1'b0);
        check("after_rst_done", 32'(done), 32'd1);
        check("after_rst_fired", 32'(fire_seen), 32'h03);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NCH; i++) begin
                n = int'($urandom_range(0, 9));
                mode[i] = (n < 6) ? M_NORMAL : (n - 6);
                dly[i]  = int'($urandom_range(1, 12));
            end
            rm = NCH'($urandom);
            run_watch(rm, 2000, 1'b0);
            check("rand_done", 32'(done), 32'd1);
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
